adr_fifo_wr_arb: RTL and testbench

- Round-robin write arbiter that shares one address FIFO write port between NUM_REQ requesters.
- Grants are message-granular: a requester keeps the port from its first beat through the beat flagged req_last.
- A new grant is issued only when the FIFO reports enough free space.
- Sits between the per-lane address producers and the address FIFO.

---
 rtl/adr_fifo_wr_arb.sv | 185 ++++++++++++++++++
 tb/tb_adr_fifo_wr_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adr_fifo_wr_arb.sv
// adr_fifo_wr_arb
//   Round-robin arbiter sharing one address-FIFO write port between NUM_REQ
//   requesters. A grant covers a whole message (first beat through req_last)
//   and is only issued when the FIFO reports at least MIN_SPACE free entries.
//   A granted requester that stays idle for TIMEOUT cycles loses the grant.
//
// Optional feature (compile-time macro ADR_FIFO_WR_ARB_STRICT0_EN):
//   requester 0 wins every arbitration it takes part in; the others keep
//   round-robin among themselves and requester-0 grants leave rr untouched.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   req_valid     per-requester beat valid
//   req_last      per-requester last beat of message
//   req_data      requester i at [i*WIDTH +: WIDTH]
//   req_ready     per-requester beat accept
//   fifo_wr       FIFO write strobe
//   fifo_wdata    FIFO write data (combinational from granted lane)
//   fifo_full     FIFO full flag
//   fifo_space    FIFO free-entry count (one cycle stale)
//   grant_id      current/last grant index
//   busy          high while in GRANT
//   timeout_err   one-cycle pulse when a grant is revoked for idleness
module adr_fifo_wr_arb #(
  parameter  int WIDTH     = 64,
  parameter  int DEPTH     = 3,
  parameter  int NUM_REQ   = 4,
  parameter  int MIN_SPACE = 2,
  parameter  int TIMEOUT   = 15,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wr,
  output logic [WIDTH-1:0]         fifo_wdata,
  input  logic                     fifo_full,
  input  logic [DEPTH:0]           fifo_space,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

  localparam logic [7:0]     IDLE_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [DEPTH:0] SPACE_MIN  = (DEPTH+1)'(MIN_SPACE);
  localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   grant_id_nxt;
  logic [IDW-1:0]   rr, rr_nxt, rr_adv;
  logic [7:0]       idle_cnt, idle_cnt_nxt;

  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [IDW-1:0]     win;
  logic               g_valid, g_last, beat_acc;
  logic [WIDTH-1:0]   g_data;

  // Granted-lane view: mux by comparison so non-power-of-two NUM_REQ needs
  // no out-of-range index handling.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign fifo_wdata = g_data;

  // Arbitration: first candidate at or above rr, then wrap to the bottom.
  always_comb begin
`ifdef ADR_FIFO_WR_ARB_STRICT0_EN
    cand  = {req_valid[NUM_REQ-1:1], 1'b0};
    found = req_valid[0];
    win   = '0;
`else
    cand  = req_valid;
    found = 1'b0;
    win   = '0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[i] && (IDW'(i) >= rr)) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
  end

  // Pointer value after a grant ends (message complete or revoked).
  always_comb begin
    rr_adv = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
`ifdef ADR_FIFO_WR_ARB_STRICT0_EN
    if (grant_id == '0) begin
      rr_adv = rr;
    end
`endif
  end

  always_comb begin
    state_nxt    = state;
    grant_id_nxt = grant_id;
    rr_nxt       = rr;
    idle_cnt_nxt = idle_cnt;
    req_ready    = '0;
    fifo_wr      = 1'b0;
    busy         = 1'b0;
    timeout_err  = 1'b0;
    beat_acc     = 1'b0;
    case (state)
      IDLE: begin
        idle_cnt_nxt = '0;
        if (found && (fifo_space >= SPACE_MIN)) begin
          grant_id_nxt = win;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        busy = 1'b1;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant_id == IDW'(i)) begin
            req_ready[i] = ~fifo_full;
          end
        end
        beat_acc = g_valid & ~fifo_full;
        fifo_wr  = beat_acc;
        if (beat_acc) begin
          idle_cnt_nxt = '0;
          if (g_last) begin
            state_nxt = SETTLE;
            rr_nxt    = rr_adv;
          end
        end else if (!g_valid && !fifo_full) begin
          // A full FIFO freezes the counter; only requester silence counts.
          if (idle_cnt == IDLE_LIMIT) begin
            timeout_err  = 1'b1;
            state_nxt    = SETTLE;
            rr_nxt       = rr_adv;
            idle_cnt_nxt = '0;
          end else begin
            idle_cnt_nxt = idle_cnt + 1'b1;
          end
        end
      end
      SETTLE: begin
        // One dead cycle so the next space check sees post-message occupancy.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
      rr       <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_id_nxt;
      rr       <= rr_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_adr_fifo_wr_arb.sv
// Scoreboard bench for adr_fifo_wr_arb: lane producers feed beats from
// per-lane queues, expected writes are queued when a message is issued and
// a monitor compares every FIFO write against that queue.
module tb_adr_fifo_wr_arb;
  localparam int WIDTH     = 64;
  localparam int DEPTH     = 3;
  localparam int NUM_REQ   = 4;
  localparam int MIN_SPACE = 2;
  localparam int TIMEOUT   = 15;
  localparam int IDW       = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_wr;
  logic [WIDTH-1:0]         fifo_wdata;
  logic                     fifo_full;
  logic [DEPTH:0]           fifo_space;
  logic [IDW-1:0]           grant_id;
  logic                     busy;
  logic                     timeout_err;

  adr_fifo_wr_arb #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ),
    .MIN_SPACE(MIN_SPACE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full), .fifo_space(fifo_space),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  int wr_times[$];
  logic [IDW+WIDTH-1:0] exp_q[$];
  logic [IDW+WIDTH-1:0] e;
  logic [WIDTH:0]       lane_q[NUM_REQ][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input int lane, input int msg, input int beat);
    return {8'hD0, 32'h0, 8'(lane), 8'(msg), 8'(beat)};
  endfunction

  // Queue a message on a lane; only the first n_exp beats are expected to
  // reach the FIFO.
  task automatic send(input int lane, input int msg, input int nbeats,
                      input bit with_last, input int n_exp);
    for (int b = 0; b < nbeats; b++) begin
      lane_q[lane].push_back({1'(with_last && (b == nbeats - 1)), mk(lane, msg, b)});
      if (b < n_exp) exp_q.push_back({IDW'(lane), mk(lane, msg, b)});
    end
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n = 0;
    while (wr_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (wr_count < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d writes expected %0d", name, wr_count, target);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d writes still pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Lane producers: acceptance sampled mid-cycle, queues advanced after edge.
  initial begin
    logic [NUM_REQ-1:0] acc;
    logic [WIDTH:0]     head;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        if (lane_q[i].size() > 0) begin
          head = lane_q[i][0];
          req_valid[i] = 1'b1;
          req_last[i]  = head[WIDTH];
          req_data[i*WIDTH +: WIDTH] = head[WIDTH-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          req_data[i*WIDTH +: WIDTH] = '0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset && fifo_wr) begin
      wr_count++;
      wr_times.push_back(cyc);
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got id %0d data %h expected no write", grant_id, fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_id", 64'(grant_id), 64'(e[IDW+WIDTH-1:WIDTH]));
        check("wr_data", 64'(fifo_wdata), 64'(e[WIDTH-1:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int wc;
    int a;
    bit seen;
    int n;
    reset      = 1'b1;
    fifo_full  = 1'b0;
    fifo_space = 4'd8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(req_ready), 64'd0);
    check("reset_wr", 64'(fifo_wr), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_timeout", 64'(timeout_err), 64'd0);
    check("reset_gid", 64'(grant_id), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Round robin: four lanes, 2-beat messages, lane 0 has a second message.
    wr_times.delete();
`ifdef ADR_FIFO_WR_ARB_STRICT0_EN
    send(0, 0, 2, 1, 2); send(0, 1, 2, 1, 2);
    send(1, 0, 2, 1, 2); send(2, 0, 2, 1, 2); send(3, 0, 2, 1, 2);
`else
    send(0, 0, 2, 1, 2); send(1, 0, 2, 1, 2); send(2, 0, 2, 1, 2);
    send(3, 0, 2, 1, 2); send(0, 1, 2, 1, 2);
`endif
    wait_drain(100, "rr_drain");
    check("rr_write_count", 64'(wr_times.size()), 64'd10);
    if (wr_times.size() >= 10) begin
      check("rr_pair_gap", 64'(wr_times[1] - wr_times[0]), 64'd1);
      check("rr_settle_gap", 64'(wr_times[2] - wr_times[1]), 64'd3);
      check("rr_span", 64'(wr_times[9] - wr_times[0]), 64'd17);
    end

    // Reset during beat 2 of a 4-beat message from lane 2 (rr is 1 here).
    wc = wr_count;
    send(2, 0, 4, 1, 1);
    wait_writes(wc + 1, 50, "rst_first_beat");
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wr", 64'(fifo_wr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    lane_q[2].delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    check("rst_pending", 64'(exp_q.size()), 64'd0);
    send(0, 2, 1, 1, 1);
    send(2, 1, 1, 1, 1);
    wait_drain(50, "rst_drain");

    // Space gating on lane 1.
    fifo_space = 4'd1;
    wc = wr_count;
    send(1, 1, 1, 1, 1);
    repeat (6) begin
      @(negedge clk);
      check("gate_busy", 64'(busy), 64'd0);
    end
    check("gate_no_write", 64'(wr_count - wc), 64'd0);
    @(posedge clk); #2 fifo_space = 4'd2;
    @(negedge clk);
    check("gate_idle_cycle", 64'(busy), 64'd0);
    @(negedge clk);
    check("gate_busy_next", 64'(busy), 64'd1);
    check("gate_gid", 64'(grant_id), 64'd1);
    check("gate_wr", 64'(fifo_wr), 64'd1);
    wait_drain(50, "gate_drain");
    fifo_space = 4'd8;

    // Full stall in the middle of a 3-beat message on lane 2.
    wc = wr_count;
    send(2, 2, 3, 1, 3);
    wait_writes(wc + 1, 50, "full_first_beat");
    @(posedge clk); #2 fifo_full = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("full_ready", 64'(req_ready[2]), 64'd0);
      check("full_no_timeout", 64'(timeout_err), 64'd0);
      check("full_no_wr", 64'(fifo_wr), 64'd0);
    end
    @(posedge clk); #2 fifo_full = 1'b0;
    wait_drain(50, "full_drain");

    // Timeout: lane 3 sends one beat without last, then goes quiet.
    wc = wr_count;
    send(3, 3, 1, 0, 1);
    wait_writes(wc + 1, 50, "to_first_beat");
    a = last_wr_cyc;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk); #1;
      n++;
      if (timeout_err) seen = 1'b1;
    end
    check("timeout_seen", 64'(seen), 64'd1);
    if (seen) check("timeout_delay", 64'(cyc - a), 64'd15);
    @(negedge clk);
    check("timeout_pulse_width", 64'(timeout_err), 64'd0);
    check("timeout_busy", 64'(busy), 64'd0);
    check("timeout_writes", 64'(wr_count - wc), 64'd1);
    repeat (2) @(negedge clk);
    // rr wrapped to 0: lane 0 must beat lane 3.
    send(0, 4, 1, 1, 1);
    send(3, 4, 1, 1, 1);
    wait_drain(50, "to_rr_drain");

`ifdef ADR_FIFO_WR_ARB_STRICT0_EN
    // Strict priority: lane 1 only after lane 0 stops requesting.
    send(0, 5, 1, 1, 1); send(0, 6, 1, 1, 1); send(0, 7, 1, 1, 1);
    send(1, 5, 1, 1, 1); send(1, 6, 1, 1, 1);
    wait_drain(80, "strict_drain");
`endif

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
